d_cache_tag_ctrl: RTL and testbench
===================================

// Module: d_cache_tag_ctrl
// PURPOSE
//  Sequencer for the 64-entry direct-mapped D-cache tag RAM (1-cycle registered read, read XOR write per cycle).
//  Takes LSU lookup requests, issues the tag read, compares, and on a miss runs a line-refill handshake
//  to the memory side. It then writes the new {valid,tag}. Also owns the invalidate sweep after reset and on flush.
// PARAMETERS
//  ADDR_W    64  physical address width
//  INDEX_W   6   set index width (sets = 2**INDEX_W)
//  OFFSET_W  3   byte offset width (8-byte line)
//  TAG_W     55  ADDR_W-INDEX_W-OFFSET_W; tag = addr[63:9], index = addr[8:3]
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous reset, active low
//  req_valid      in   1       LSU lookup request
//  req_ready      out  1       controller accepts request (IDLE only)
//  req_addr       in   64      lookup address
//  resp_valid     out  1       lookup result valid
//  resp_ready     in   1       LSU accepts result
//  resp_hit       out  1       1 = hit, 0 = was miss (line now refilled)
//  flush_i        in   1       invalidate-all request (sampled in IDLE only)
//  flush_done     out  1       one-cycle pulse at end of any sweep
//  mem_req_valid  out  1       refill request to memory side
//  mem_req_ready  in   1       memory accepted refill request
//  mem_req_addr   out  64      line-aligned refill address (offset bits zero)
//  mem_rsp_valid  in   1       refill line delivered (data path handled elsewhere)
//  tag_addr_o     out  6       tag RAM index
//  tag_we_o       out  1       tag RAM write enable
//  tag_wdata_o    out  56      {valid, tag} to tag RAM
//  tag_rdata_i    in   55      tag RAM read tag
//  tag_valid_i    in   1       tag RAM read valid bit
// BEHAVIOUR
//  States: INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UPDATE, RESP, FLUSH.
//  Reset (async, rst=0): state=INIT, sweep counter=0, captured addr=0; all outputs 0.
//  INIT/FLUSH: tag_we_o=1, tag_addr_o=counter, tag_wdata_o=0; counter 0..63, one entry/cycle.
//   At 63: flush_done=1 that cycle, next=IDLE. Exactly 64 write cycles. req_ready=0 throughout.
//  IDLE: req_ready=1. flush_i has priority over req_valid: flush_i=1 -> FLUSH, request not accepted.
//   req_valid&req_ready: capture req_addr; drive tag_addr_o=req_addr[8:3], tag_we_o=0 the same cycle. Next=LOOKUP.
//  LOOKUP: tag_addr_o holds captured index, tag_we_o=0.
//   hit = tag_valid_i & (tag_rdata_i==cap_addr[63:9]).
//   hit -> RESP with resp_hit=1; miss -> MISS_REQ.
//  MISS_REQ: mem_req_valid=1, mem_req_addr={cap_addr[63:3],3'b0}; held stable until mem_req_ready; then MISS_WAIT.
//  MISS_WAIT: mem_req_valid=0; wait mem_rsp_valid (any number of cycles); then UPDATE.
//   mem_rsp_valid outside MISS_WAIT is ignored.
//  UPDATE: one cycle tag_we_o=1, tag_addr_o=index, tag_wdata_o={1'b1,cap_addr[63:9]}; next=RESP, resp_hit=0.
//  RESP: resp_valid=1, resp_hit stable until resp_ready; then IDLE. Same-cycle new req not accepted (req_ready=0).
//  Latency: accept at T -> hit resp_valid at T+2; miss adds handshake wait + 1 UPDATE cycle.
//  tag_we_o is never 1 in a cycle whose read result is consumed; reads only in IDLE-accept and LOOKUP.
//  flush_i outside IDLE is ignored, not queued. Reset mid-operation aborts everything:
//   mem_req_valid and resp_valid drop asynchronously, then full INIT sweep.
//  Tag RAM contents are not reset, so no lookup is served before the INIT sweep completes.
// TESTING
//  Release rst -> 64 consecutive cycles tag_we_o=1, tag_addr_o 0..63, wdata 0. flush_done at 64th. req_ready=0 until IDLE.
//  req 0x8000_0000 -> miss; mem_req_addr 0x8000_0000; after mem_rsp_valid, write idx 0 wdata {1,0x40_0000}; resp_hit=0.
//   Repeat same address -> resp_valid at T+2, resp_hit=1, no mem_req_valid.
//  req 0x8000_0200 (idx 0, tag 0x40_0001) -> miss, idx 0 rewritten.
//   Then 0x8000_0000 -> miss again.
//  mem_req_ready low 5 cycles, resp_ready low 3 cycles -> mem_req_addr / resp_hit held stable.
//   Exactly one UPDATE write occurs.
//  flush_i=1 and req_valid=1 together in IDLE -> 64-cycle sweep, request not accepted. Prior hit address now misses.
//  Assert rst during MISS_WAIT -> outputs 0 immediately; INIT sweep restarts at index 0 on release.

Source files
------------

// File: rtl/d_cache_tag_ctrl.sv
// Tag-RAM sequencer for a 64-set direct-mapped D-cache: lookup, compare, refill handshake,
// tag update, and the invalidate sweep after reset and on flush.
module d_cache_tag_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hit,
    input  logic               flush_i,
    output logic               flush_done,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    output logic [INDEX_W-1:0] tag_addr_o,
    output logic               tag_we_o,
    output logic [TAG_W:0]     tag_wdata_o,
    input  logic [TAG_W-1:0]   tag_rdata_i,
    input  logic               tag_valid_i
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_UPDATE,
        S_RESP,
        S_FLUSH
    } state_e;

    localparam logic [INDEX_W-1:0] LAST_IDX   = '1;
    localparam logic [INDEX_W-1:0] PENULT_IDX = {{(INDEX_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0]  LINE_MASK  = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_e              state_q;
    logic [INDEX_W-1:0]  cnt_q;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic [INDEX_W-1:0]  tag_addr_q;
    logic                tag_we_q;
    logic [TAG_W:0]      tag_wdata_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic                flush_done_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_req_addr_q;

    logic [TAG_W-1:0]    cap_tag;
    logic                lookup_hit;

    assign cap_tag    = cap_addr_q[ADDR_W-1 -: TAG_W];
    assign lookup_hit = tag_valid_i && (tag_rdata_i == cap_tag);

    // The accepting IDLE cycle must launch the tag read with the incoming index, so that one
    // address bypasses the output register.
    assign tag_addr_o    = (state_q == S_IDLE) ? req_addr[OFFSET_W +: INDEX_W] : tag_addr_q;
    assign tag_we_o      = tag_we_q;
    assign tag_wdata_o   = tag_wdata_q;
    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_hit      = resp_hit_q;
    assign flush_done    = flush_done_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

    // NOTE: all state and registered outputs live in one clocked block and use non-blocking
    // assignments only, so every branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_INIT;
            cnt_q           <= '0;
            cap_addr_q      <= '0;
            tag_addr_q      <= '0;
            tag_we_q        <= 1'b0;
            tag_wdata_q     <= '0;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            flush_done_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                // The first cycle out of reset arms the sweep; each later cycle writes one set.
                S_INIT, S_FLUSH: begin
                    if (!tag_we_q) begin
                        tag_we_q    <= 1'b1;
                        tag_addr_q  <= cnt_q;
                        tag_wdata_q <= '0;
                    end else if (cnt_q == LAST_IDX) begin
                        tag_we_q    <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q        <= cnt_q + INDEX_W'(1);
                        tag_addr_q   <= cnt_q + INDEX_W'(1);
                        flush_done_q <= (cnt_q == PENULT_IDX);
                    end
                end
                S_IDLE: begin
                    if (flush_i) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        tag_addr_q  <= '0;
                        tag_wdata_q <= '0;
                        tag_we_q    <= 1'b1;
                        state_q     <= S_FLUSH;
                    end else if (req_valid) begin
                        req_ready_q <= 1'b0;
                        cap_addr_q  <= req_addr;
                        tag_addr_q  <= req_addr[OFFSET_W +: INDEX_W];
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= cap_addr_q & LINE_MASK;
                        state_q         <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    if (mem_rsp_valid) begin
                        tag_we_q    <= 1'b1;
                        tag_wdata_q <= {1'b1, cap_tag};
                        state_q     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    tag_we_q     <= 1'b0;
                    tag_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= 1'b0;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_hit_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_tag_ctrl.sv
// Directed bench for d_cache_tag_ctrl with a behavioural 1-cycle registered tag RAM.
module tb_d_cache_tag_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic        flush_i;
    logic        flush_done;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [5:0]  tag_addr_o;
    logic        tag_we_o;
    logic [55:0] tag_wdata_o;
    logic [54:0] tag_rdata_i;
    logic        tag_valid_i;

    int vectors = 0;
    int errors  = 0;
    int wr_count = 0;

    logic [55:0] ram [64];
    logic [55:0] rd_q = '0;

    d_cache_tag_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_hit      (resp_hit),
        .flush_i       (flush_i),
        .flush_done    (flush_done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .tag_addr_o    (tag_addr_o),
        .tag_we_o      (tag_we_o),
        .tag_wdata_o   (tag_wdata_o),
        .tag_rdata_i   (tag_rdata_i),
        .tag_valid_i   (tag_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag RAM: one access per cycle, either a write or a registered read.
    always @(posedge clk) begin
        if (tag_we_o) begin
            ram[tag_addr_o] <= tag_wdata_o;
            wr_count        <= wr_count + 1;
        end else begin
            rd_q <= ram[tag_addr_o];
        end
    end
    assign tag_rdata_i = rd_q[54:0];
    assign tag_valid_i = rd_q[55];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_sweep_start();
        int n = 0;
        while (!tag_we_o && n < 8) begin
            tick();
            n++;
        end
        check("sweep_start", tag_we_o, 1);
    endtask

    // Current cycle must be the first sweep write.
    task automatic check_sweep();
        int wr0 = wr_count;
        for (int i = 0; i < 64; i++) begin
            check("sweep_ctl", {tag_we_o, tag_addr_o, req_ready, flush_done},
                  {1'b1, 6'(i), 1'b0, 1'(i == 63)});
            check("sweep_wdata", tag_wdata_o, 0);
            tick();
        end
        check("sweep_end", {tag_we_o, req_ready, flush_done, resp_valid, mem_req_valid}, 5'b01000);
        check("sweep_writes", wr_count - wr0, 64);
    endtask

    task automatic transact(input logic [63:0] addr, input bit exp_hit,
                            input int mrdy_wait, input int rsp_wait, input int rrdy_wait);
        logic [5:0]  idx;
        logic [54:0] tag;
        logic [63:0] line;
        int          wr0;
        idx  = addr[8:3];
        tag  = addr[63:9];
        line = {addr[63:3], 3'b000};
        wr0  = wr_count;

        req_addr  = addr;
        req_valid = 1'b1;
        #1;
        check("accept_ready", req_ready, 1);
        check("accept_rd_idx", tag_addr_o, 64'(idx));
        tick();
        req_valid = 1'b0;
        check("lookup", {tag_we_o, tag_addr_o, req_ready, mem_req_valid, resp_valid}, {1'b0, idx, 3'b000});
        tick();
        if (exp_hit) begin
            check("hit_resp", {resp_valid, resp_hit, mem_req_valid}, 3'b110);
        end else begin
            check("miss_req", {mem_req_valid, resp_valid}, 2'b10);
            check("miss_addr", mem_req_addr, line);
            mem_rsp_valid = 1'b1;
            for (int i = 0; i < mrdy_wait; i++) begin
                tick();
                check("req_hold", {mem_req_valid, resp_valid, tag_we_o}, 3'b100);
                check("req_addr_hold", mem_req_addr, line);
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            check("wait_idle", {mem_req_valid, tag_we_o, resp_valid}, 3'b000);
            for (int i = 0; i < rsp_wait; i++) begin
                tick();
                check("wait_hold", {mem_req_valid, tag_we_o, resp_valid}, 3'b000);
            end
            mem_rsp_valid = 1'b1;
            tick();
            mem_rsp_valid = 1'b0;
            check("update_ctl", {tag_we_o, tag_addr_o, resp_valid}, {1'b1, idx, 1'b0});
            check("update_wdata", tag_wdata_o, {8'h0, 1'b1, tag});
            tick();
            check("miss_resp", {resp_valid, resp_hit, tag_we_o}, 3'b100);
        end

        flush_i   = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < rrdy_wait; i++) begin
            tick();
            check("resp_hold", {resp_valid, resp_hit, req_ready, tag_we_o}, {1'b1, exp_hit, 2'b00});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        flush_i    = 1'b0;
        check("back_idle", {req_ready, resp_valid, tag_we_o, mem_req_valid}, 4'b1000);
        check("write_count", wr_count - wr0, exp_hit ? 0 : 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        resp_ready    = 1'b0;
        flush_i       = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;

        repeat (3) tick();
        check("rst_ctl", {req_ready, resp_valid, resp_hit, flush_done, mem_req_valid, tag_we_o}, 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_tag", {tag_addr_o, tag_wdata_o}, 0);

        // A pending request during the INIT sweep must wait for it to finish.
        req_addr  = 64'h8000_0000;
        req_valid = 1'b1;
        rst       = 1'b1;
        wait_sweep_start();
        check_sweep();
        req_valid = 1'b0;

        transact(64'h8000_0000, 1'b0, 0, 0, 0);
        transact(64'h8000_0000, 1'b1, 0, 0, 0);
        transact(64'h8000_0200, 1'b0, 0, 0, 0);
        transact(64'h8000_0000, 1'b0, 5, 2, 3);
        transact(64'h1234_567D, 1'b0, 1, 0, 1);
        transact(64'h1234_567D, 1'b1, 0, 0, 2);
        transact(64'h8000_0000, 1'b1, 0, 0, 0);

        // Flush wins over a simultaneous request.
        flush_i   = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        #1;
        check("flush_idle_ready", req_ready, 1);
        tick();
        flush_i   = 1'b0;
        req_valid = 1'b0;
        check_sweep();
        transact(64'h8000_0000, 1'b0, 0, 1, 0);

        // Reset while waiting for the refill line.
        req_addr  = 64'h1234_567D;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_miss_req", {mem_req_valid, mem_req_addr}, {1'b1, 64'h1234_5678});
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("mid_wait", {mem_req_valid, tag_addr_o}, {1'b0, 6'd15});
        rst = 1'b0;
        #1;
        check("async_rst_ctl", {mem_req_valid, resp_valid, req_ready, tag_we_o, flush_done}, 0);
        check("async_rst_addr", {mem_req_addr, tag_addr_o}, 0);
        tick();
        tick();
        rst = 1'b1;
        wait_sweep_start();
        check_sweep();
        transact(64'h8000_0000, 1'b0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
